dct_pingpong_ctrl: RTL and testbench



---
 rtl/dct_pingpong_ctrl.sv | 158 +++++++++++++++
 tb/tb_dct_pingpong_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dct_pingpong_ctrl.sv
// Ping-pong bank sequencer for the 2-D DCT transpose stage: row-major fill, column-major drain.
// Optional status logic (overflow_err, blk_cnt) is built when DCT_PP_STATUS_EN is defined.
module dct_pingpong_ctrl #(
    parameter int unsigned N      = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        wr_en,
    output logic                        wr_bank,
    output logic [2*$clog2(N)-1:0]      wr_addr,
    input  logic                        out_ready,
    output logic                        rd_en,
    output logic                        rd_bank,
    output logic [2*$clog2(N)-1:0]      rd_addr,
    output logic                        out_valid,
    output logic                        out_first,
    output logic                        out_last,
    output logic                        overflow_err,
    output logic [15:0]                 blk_cnt
);
    localparam int unsigned LW  = $clog2(N);
    localparam int unsigned AW  = 2 * LW;
    localparam int unsigned LAT = RD_LAT;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    bank_state_t     state_q [2];
    bank_state_t     state_d [2];
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [LW-1:0]   rd_row_q, rd_row_d;
    logic [LW-1:0]   rd_col_q, rd_col_d;
    logic [LAT-1:0]  vld_q, vld_d;
    logic [LAT-1:0]  first_q, first_d;
    logic [LAT-1:0]  last_q, last_d;

    logic wr_last;
    logic rd_first;
    logic rd_last;
    logic rd_avail;

    assign in_ready = (state_q[wr_bank_q] == EMPTY) || (state_q[wr_bank_q] == FILLING);
    assign wr_en    = in_valid & in_ready;
    assign rd_avail = (state_q[rd_bank_q] == FULL) || (state_q[rd_bank_q] == DRAINING);
    assign rd_en    = out_ready & rd_avail;

    assign wr_last  = &wr_addr_q;
    assign rd_first = (rd_row_q == '0) && (rd_col_q == '0);
    assign rd_last  = (&rd_row_q) && (&rd_col_q);

    assign wr_bank   = wr_bank_q;
    assign wr_addr   = wr_addr_q;
    assign rd_bank   = rd_bank_q;
    assign rd_addr   = {rd_row_q, rd_col_q};
    assign out_valid = vld_q[LAT-1];
    assign out_first = first_q[LAT-1];
    assign out_last  = last_q[LAT-1];

    // Next-state: bank lifecycle, address walkers and the read-latency strobe pipeline.
    always_comb begin
        for (int b = 0; b < 2; b++) state_d[b] = state_q[b];
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_addr_d = wr_addr_q;
        rd_row_d  = rd_row_q;
        rd_col_d  = rd_col_q;
        vld_d     = (vld_q << 1)   | LAT'(rd_en);
        first_d   = (first_q << 1) | LAT'(rd_en & rd_first);
        last_d    = (last_q << 1)  | LAT'(rd_en & rd_last);

        if (wr_en) begin
            if (wr_last) begin
                state_d[wr_bank_q] = FULL;
                wr_bank_d          = ~wr_bank_q;
                wr_addr_d          = '0;
            end else begin
                state_d[wr_bank_q] = FILLING;
                wr_addr_d          = wr_addr_q + AW'(1);
            end
        end

        // Write and read banks are never in overlapping states, so both updates can apply.
        if (rd_en) begin
            if (rd_last) begin
                state_d[rd_bank_q] = EMPTY;
                rd_bank_d          = ~rd_bank_q;
            end else begin
                state_d[rd_bank_q] = DRAINING;
            end
            rd_row_d = rd_row_q + LW'(1);
            if (&rd_row_q) rd_col_d = rd_col_q + LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) state_q[b] <= EMPTY;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_addr_q <= '0;
            rd_row_q  <= '0;
            rd_col_q  <= '0;
            vld_q     <= '0;
            first_q   <= '0;
            last_q    <= '0;
        end else begin
            for (int b = 0; b < 2; b++) state_q[b] <= state_d[b];
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_addr_q <= wr_addr_d;
            rd_row_q  <= rd_row_d;
            rd_col_q  <= rd_col_d;
            vld_q     <= vld_d;
            first_q   <= first_d;
            last_q    <= last_d;
        end
    end

`ifdef DCT_PP_STATUS_EN
    localparam int unsigned CW = 16;

    logic          ovf_q, ovf_d;
    logic [CW-1:0] blk_q, blk_d;

    // Sticky overflow and drained-block counter (wraps naturally).
    always_comb begin
        ovf_d = ovf_q | (in_valid & ~in_ready);
        blk_d = blk_q;
        if (rd_en & rd_last) blk_d = blk_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            blk_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            blk_q <= blk_d;
        end
    end

    assign overflow_err = ovf_q;
    assign blk_cnt      = blk_q;
`else
    assign overflow_err = 1'b0;
    assign blk_cnt      = '0;
`endif

endmodule

// File: tb/tb_dct_pingpong_ctrl.sv
// Bench for dct_pingpong_ctrl (RD_LAT=1 and RD_LAT=3 instances) against a fill/drain count model.
module tb_dct_pingpong_ctrl;
    localparam int N  = 8;
    localparam int NN = N * N;

    logic clk;
    logic rst;
    logic in_valid;
    logic out_ready;

    logic       ir1, we1, wbk1, re1, rbk1, ov1, of1, ol1, oe1;
    logic [5:0] wa1, ra1;
    logic [15:0] bc1;
    logic       ir3, we3, wbk3, re3, rbk3, ov3, of3, ol3, oe3;
    logic [5:0] wa3, ra3;
    logic [15:0] bc3;

    dct_pingpong_ctrl #(.N(N), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(ir1),
        .wr_en(we1), .wr_bank(wbk1), .wr_addr(wa1),
        .out_ready(out_ready),
        .rd_en(re1), .rd_bank(rbk1), .rd_addr(ra1),
        .out_valid(ov1), .out_first(of1), .out_last(ol1),
        .overflow_err(oe1), .blk_cnt(bc1)
    );

    dct_pingpong_ctrl #(.N(N), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(ir3),
        .wr_en(we3), .wr_bank(wbk3), .wr_addr(wa3),
        .out_ready(out_ready),
        .rd_en(re3), .rd_bank(rbk3), .rd_addr(ra3),
        .out_valid(ov3), .out_first(of3), .out_last(ol3),
        .overflow_err(oe3), .blk_cnt(bc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: per-bank sample counts written and read, plus bank pointers.
    int fill [2];
    int drained [2];
    int wb, rb;
    logic ovf_m;
    int blk_m;
    logic [2:0] q1 [$];
    logic [2:0] q3 [$];

    logic e_ir, e_we, e_re, e_f, e_l, e_ovf;
    int   e_wa, e_ra, e_blk, e_k;

    function automatic void model_reset();
        for (int b = 0; b < 2; b++) begin
            fill[b]    = 0;
            drained[b] = 0;
        end
        wb = 0;
        rb = 0;
        ovf_m = 1'b0;
        blk_m = 0;
        q1.delete();
        q3.delete();
        q1.push_back(3'b000);
        repeat (3) q3.push_back(3'b000);
    endfunction

    function automatic void set_exp(input logic v, input logic r);
        e_ir = fill[wb] < NN;
        e_we = v && e_ir;
        e_wa = fill[wb] % NN;
        e_k  = drained[rb];
        e_re = r && (fill[rb] == NN);
        e_ra = (e_k % N) * N + e_k / N;
        e_f  = e_re && (e_k == 0);
        e_l  = e_re && (e_k == NN - 1);
`ifdef DCT_PP_STATUS_EN
        e_ovf = ovf_m;
        e_blk = blk_m;
`else
        e_ovf = 1'b0;
        e_blk = 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string p, input logic ir, input logic we, input logic wbk,
                           input logic [5:0] wa, input logic re, input logic rbk,
                           input logic [5:0] ra, input logic ov, input logic of,
                           input logic ol, input logic oe, input logic [15:0] bc,
                           input logic [2:0] pe);
        chk({p, "_in_ready"},  32'(ir),  32'(e_ir));
        chk({p, "_wr_en"},     32'(we),  32'(e_we));
        chk({p, "_wr_bank"},   32'(wbk), 32'(wb));
        chk({p, "_wr_addr"},   32'(wa),  32'(e_wa));
        chk({p, "_rd_en"},     32'(re),  32'(e_re));
        chk({p, "_rd_bank"},   32'(rbk), 32'(rb));
        chk({p, "_rd_addr"},   32'(ra),  32'(e_ra));
        chk({p, "_out_valid"}, 32'(ov),  32'(pe[2]));
        chk({p, "_out_first"}, 32'(of),  32'(pe[1]));
        chk({p, "_out_last"},  32'(ol),  32'(pe[0]));
        chk({p, "_overflow"},  32'(oe),  32'(e_ovf));
        chk({p, "_blk_cnt"},   32'(bc),  32'(e_blk));
    endtask

    task automatic check_both();
        chk_all("lat1", ir1, we1, wbk1, wa1, re1, rbk1, ra1, ov1, of1, ol1, oe1, bc1, q1[0]);
        chk_all("lat3", ir3, we3, wbk3, wa3, re3, rbk3, ra3, ov3, of3, ol3, oe3, bc3, q3[0]);
    endtask

    // One clock cycle: drive inputs, compare at negedge, advance the model.
    task automatic step(input logic v, input logic r);
        logic [2:0] cur;
        in_valid  = v;
        out_ready = r;
        @(negedge clk);
        set_exp(v, r);
        check_both();
        cur = {e_re, e_f, e_l};
        q1.push_back(cur);
        void'(q1.pop_front());
        q3.push_back(cur);
        void'(q3.pop_front());
        if (v && !e_ir) ovf_m = 1'b1;
        if (e_we) begin
            fill[wb]++;
            if (fill[wb] == NN) wb ^= 1;
        end
        if (e_re) begin
            drained[rb]++;
            if (drained[rb] == NN) begin
                fill[rb]    = 0;
                drained[rb] = 0;
                rb ^= 1;
                blk_m = (blk_m + 1) % 65536;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset, checked while held, released away from the clock edge.
    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        set_exp(1'b0, 1'b0);
        check_both();
        chk("reset_in_ready_const", 32'(ir1), 32'd1);
        chk("reset_out_valid_const", 32'(ov1), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;

        // First block and four back-to-back blocks at full rate.
        do_reset();
        repeat (4 * NN + 80) step(1'b1, 1'b1);

        // Consumer stalled: both banks fill, then overflow, then drain.
        do_reset();
        repeat (130) step(1'b1, 1'b0);
        repeat (140) step(1'b0, 1'b1);

        // Drain with out_ready toggling every cycle.
        do_reset();
        repeat (NN) step(1'b1, 1'b0);
        for (int i = 0; i < 160; i++) step(1'b0, (i % 2) == 0);

        // Random producer/consumer traffic.
        do_reset();
        repeat (1500) step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);

        // Reset during read index 20 of bank 1.
        do_reset();
        guard = 0;
        while (!(rb == 1 && drained[1] == 20) && guard < 400) begin
            step(1'b1, 1'b1);
            guard++;
        end
        chk("reach_bank1_read20", 32'(guard < 400), 32'd1);
        do_reset();
        repeat (200) step(1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
